// File: rtl/md4_candidate_driver.sv
// md4_candidate_driver
// Host-side master for one md4 core. It accepts a password candidate, feeds
// its bytes to the core on read requests, and collects the 16 digest bytes.
// It then compares the digest with the target hash and reports a one-cycle
// result pulse carrying the match, timeout and captured-digest information.
module md4_candidate_driver #(
  parameter int MAX_LEN        = 8,
  parameter int LEN_W          = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 CAND_VALID,
  output logic                 CAND_READY,
  input  logic [MAX_LEN*8-1:0] CAND_DATA,
  input  logic [LEN_W-1:0]     CAND_LEN,
  input  logic [127:0]         TARGET_HASH,
  output logic                 MD4_START,
  input  logic                 MD4_BUSY,
  input  logic                 MD4_DONE,
  output logic [63:0]          MD4_INPUT_SIZE,
  output logic [7:0]           MD4_INPUT_BYTE,
  output logic                 MD4_INPUT_EMPTY,
  input  logic                 MD4_INPUT_READ,
  input  logic [7:0]           MD4_OUTPUT_BYTE,
  output logic                 MD4_OUTPUT_FULL,
  input  logic                 MD4_OUTPUT_WRITE,
  output logic                 RESULT_VALID,
  output logic                 RESULT_MATCH,
  output logic                 RESULT_TIMEOUT,
  output logic [127:0]         RESULT_HASH
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  // Pick candidate byte idx out of the packed candidate word.
  function automatic logic [7:0] sel_byte(input logic [MAX_LEN*8-1:0] data,
                                          input logic [LEN_W-1:0]     idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < MAX_LEN; i++) begin
      b = (idx == LEN_W'(i)) ? data[8*i +: 8] : b;
    end
    return b;
  endfunction

  // Registered state
  logic [1:0]           state_r;
  logic [MAX_LEN*8-1:0] cand_r;
  logic [127:0]         target_r;
  logic [LEN_W-1:0]     len_r;
  logic [LEN_W-1:0]     rd_ptr_r;
  logic [4:0]           hash_cnt_r;
  logic                 done_seen_r;
  logic [TMR_W-1:0]     timer_r;
  logic [127:0]         digest_r;
  logic                 cand_ready_r;
  logic                 start_r;
  logic [63:0]          in_size_r;
  logic [7:0]           in_byte_r;
  logic                 in_empty_r;
  logic                 out_full_r;
  logic                 res_valid_r;
  logic                 res_match_r;
  logic                 res_timeout_r;
  logic [127:0]         res_hash_r;

  // Next-state values
  logic [1:0]           state_nxt_s;
  logic [MAX_LEN*8-1:0] cand_nxt_s;
  logic [127:0]         target_nxt_s;
  logic [LEN_W-1:0]     len_nxt_s;
  logic [LEN_W-1:0]     rd_ptr_nxt_s;
  logic [4:0]           hash_cnt_nxt_s;
  logic                 done_seen_nxt_s;
  logic [TMR_W-1:0]     timer_nxt_s;
  logic [127:0]         digest_nxt_s;
  logic                 cand_ready_nxt_s;
  logic                 start_nxt_s;
  logic [63:0]          in_size_nxt_s;
  logic [7:0]           in_byte_nxt_s;
  logic                 in_empty_nxt_s;
  logic                 out_full_nxt_s;
  logic                 res_valid_nxt_s;
  logic                 res_match_nxt_s;
  logic                 res_timeout_nxt_s;
  logic [127:0]         res_hash_nxt_s;

  // Helper terms
  logic [LEN_W-1:0] len_clamped_s;
  logic             read_acc_s;
  logic             write_acc_s;
  logic [LEN_W-1:0] rd_ptr_inc_s;
  logic [127:0]     digest_upd_s;
  logic [4:0]       hash_cnt_upd_s;
  logic             done_now_s;
  logic             finish_s;
  logic             timer_expired_s;
  logic             unused_busy_s;

  // BUSY is status only; nothing in the handshake depends on it.
  assign unused_busy_s = MD4_BUSY;

  assign len_clamped_s   = (CAND_LEN > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : CAND_LEN;
  assign read_acc_s      = (state_r == ST_RUN) && MD4_INPUT_READ && !in_empty_r;
  assign write_acc_s     = (state_r == ST_RUN) && MD4_OUTPUT_WRITE && !out_full_r;
  assign rd_ptr_inc_s    = rd_ptr_r + {{(LEN_W-1){1'b0}}, 1'b1};
  assign digest_upd_s    = write_acc_s ? {digest_r[119:0], MD4_OUTPUT_BYTE} : digest_r;
  assign hash_cnt_upd_s  = write_acc_s ? (hash_cnt_r + 5'd1) : hash_cnt_r;
  // DONE and the last digest byte may arrive in either order or together.
  assign done_now_s      = done_seen_r || MD4_DONE;
  assign finish_s        = done_now_s && (hash_cnt_upd_s == 5'd16);
  assign timer_expired_s = (timer_r == TMR_W'(TIMEOUT_CYCLES - 1));

  // Next-state logic for the IDLE -> RUN -> CHECK job sequence.
  always_comb begin
    state_nxt_s       = state_r;
    cand_nxt_s        = cand_r;
    target_nxt_s      = target_r;
    len_nxt_s         = len_r;
    rd_ptr_nxt_s      = rd_ptr_r;
    hash_cnt_nxt_s    = hash_cnt_r;
    done_seen_nxt_s   = done_seen_r;
    timer_nxt_s       = timer_r;
    digest_nxt_s      = digest_r;
    cand_ready_nxt_s  = cand_ready_r;
    start_nxt_s       = start_r;
    in_size_nxt_s     = in_size_r;
    in_byte_nxt_s     = in_byte_r;
    in_empty_nxt_s    = in_empty_r;
    out_full_nxt_s    = out_full_r;
    res_valid_nxt_s   = 1'b0;
    res_match_nxt_s   = res_match_r;
    res_timeout_nxt_s = res_timeout_r;
    res_hash_nxt_s    = res_hash_r;

    case (state_r)
      ST_IDLE: begin
        if (CAND_VALID && cand_ready_r) begin
          cand_nxt_s        = CAND_DATA;
          target_nxt_s      = TARGET_HASH;
          len_nxt_s         = len_clamped_s;
          rd_ptr_nxt_s      = {LEN_W{1'b0}};
          in_size_nxt_s     = 64'(len_clamped_s);
          in_empty_nxt_s    = (len_clamped_s == {LEN_W{1'b0}});
          in_byte_nxt_s     = (len_clamped_s == {LEN_W{1'b0}}) ? 8'h00 : CAND_DATA[7:0];
          hash_cnt_nxt_s    = 5'd0;
          done_seen_nxt_s   = 1'b0;
          timer_nxt_s       = {TMR_W{1'b0}};
          digest_nxt_s      = 128'h0;
          res_match_nxt_s   = 1'b0;
          res_timeout_nxt_s = 1'b0;
          res_hash_nxt_s    = 128'h0;
          start_nxt_s       = 1'b1;
          out_full_nxt_s    = 1'b0;
          cand_ready_nxt_s  = 1'b0;
          state_nxt_s       = ST_RUN;
        end else begin
          cand_ready_nxt_s  = 1'b1;
        end
      end

      ST_RUN: begin
        // Input side: present the next byte, or go empty after the last one.
        if (read_acc_s) begin
          rd_ptr_nxt_s = rd_ptr_inc_s;
          if (rd_ptr_inc_s == len_r) begin
            in_byte_nxt_s  = 8'h00;
            in_empty_nxt_s = 1'b1;
          end else begin
            in_byte_nxt_s  = sel_byte(cand_r, rd_ptr_inc_s);
            in_empty_nxt_s = 1'b0;
          end
        end else begin
          rd_ptr_nxt_s = rd_ptr_r;
        end

        // Output side and completion tracking.
        digest_nxt_s    = digest_upd_s;
        hash_cnt_nxt_s  = hash_cnt_upd_s;
        done_seen_nxt_s = done_now_s;
        out_full_nxt_s  = (hash_cnt_upd_s == 5'd16);
        timer_nxt_s     = timer_r + {{(TMR_W-1){1'b0}}, 1'b1};

        if (finish_s) begin
          state_nxt_s       = ST_CHECK;
          start_nxt_s       = 1'b0;
          out_full_nxt_s    = 1'b1;
          in_empty_nxt_s    = 1'b1;
          in_byte_nxt_s     = 8'h00;
          res_valid_nxt_s   = 1'b1;
          res_match_nxt_s   = (digest_upd_s == target_r);
          res_timeout_nxt_s = 1'b0;
          res_hash_nxt_s    = digest_upd_s;
        end else if (timer_expired_s) begin
          state_nxt_s       = ST_CHECK;
          start_nxt_s       = 1'b0;
          out_full_nxt_s    = 1'b1;
          in_empty_nxt_s    = 1'b1;
          in_byte_nxt_s     = 8'h00;
          res_valid_nxt_s   = 1'b1;
          res_match_nxt_s   = 1'b0;
          res_timeout_nxt_s = 1'b1;
          res_hash_nxt_s    = digest_upd_s;
        end else begin
          start_nxt_s       = 1'b1;
        end
      end

      ST_CHECK: begin
        // The result pulse is this single cycle; the next cycle is idle.
        res_valid_nxt_s  = 1'b0;
        cand_ready_nxt_s = 1'b1;
        state_nxt_s      = ST_IDLE;
      end

      default: begin
        state_nxt_s      = ST_IDLE;
        cand_ready_nxt_s = 1'b1;
        start_nxt_s      = 1'b0;
        out_full_nxt_s   = 1'b1;
        in_empty_nxt_s   = 1'b1;
        in_byte_nxt_s    = 8'h00;
        res_valid_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_r       <= ST_IDLE;
      cand_r        <= {(MAX_LEN*8){1'b0}};
      target_r      <= 128'h0;
      len_r         <= {LEN_W{1'b0}};
      rd_ptr_r      <= {LEN_W{1'b0}};
      hash_cnt_r    <= 5'd0;
      done_seen_r   <= 1'b0;
      timer_r       <= {TMR_W{1'b0}};
      digest_r      <= 128'h0;
      cand_ready_r  <= 1'b1;
      start_r       <= 1'b0;
      in_size_r     <= 64'h0;
      in_byte_r     <= 8'h00;
      in_empty_r    <= 1'b1;
      out_full_r    <= 1'b1;
      res_valid_r   <= 1'b0;
      res_match_r   <= 1'b0;
      res_timeout_r <= 1'b0;
      res_hash_r    <= 128'h0;
    end else begin
      state_r       <= state_nxt_s;
      cand_r        <= cand_nxt_s;
      target_r      <= target_nxt_s;
      len_r         <= len_nxt_s;
      rd_ptr_r      <= rd_ptr_nxt_s;
      hash_cnt_r    <= hash_cnt_nxt_s;
      done_seen_r   <= done_seen_nxt_s;
      timer_r       <= timer_nxt_s;
      digest_r      <= digest_nxt_s;
      cand_ready_r  <= cand_ready_nxt_s;
      start_r       <= start_nxt_s;
      in_size_r     <= in_size_nxt_s;
      in_byte_r     <= in_byte_nxt_s;
      in_empty_r    <= in_empty_nxt_s;
      out_full_r    <= out_full_nxt_s;
      res_valid_r   <= res_valid_nxt_s;
      res_match_r   <= res_match_nxt_s;
      res_timeout_r <= res_timeout_nxt_s;
      res_hash_r    <= res_hash_nxt_s;
    end
  end

  assign CAND_READY      = cand_ready_r;
  assign MD4_START       = start_r;
  assign MD4_INPUT_SIZE  = in_size_r;
  assign MD4_INPUT_BYTE  = in_byte_r;
  assign MD4_INPUT_EMPTY = in_empty_r;
  assign MD4_OUTPUT_FULL = out_full_r;
  assign RESULT_VALID    = res_valid_r;
  assign RESULT_MATCH    = res_match_r;
  assign RESULT_TIMEOUT  = res_timeout_r;
  assign RESULT_HASH     = res_hash_r;

endmodule

// File: tb/tb_md4_candidate_driver.sv
// Directed testbench for md4_candidate_driver. A small core model streams
// known MD4 digests; expected values are hand-computed constants.
module tb_md4_candidate_driver;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int TMO     = 20;
  localparam logic [127:0] H_EMPTY = 128'h31d6cfe0d16ae931b73c59d7e0c089c0;
  localparam logic [127:0] H_A     = 128'hbde52cb31de33e46245e05fbdbd6fb24;

  logic                 CLK = 1'b0;
  logic                 RESET_N;
  logic                 CAND_VALID;
  logic                 CAND_READY;
  logic [MAX_LEN*8-1:0] CAND_DATA;
  logic [LEN_W-1:0]     CAND_LEN;
  logic [127:0]         TARGET_HASH;
  logic                 MD4_START;
  logic                 MD4_BUSY;
  logic                 MD4_DONE;
  logic [63:0]          MD4_INPUT_SIZE;
  logic [7:0]           MD4_INPUT_BYTE;
  logic                 MD4_INPUT_EMPTY;
  logic                 MD4_INPUT_READ;
  logic [7:0]           MD4_OUTPUT_BYTE;
  logic                 MD4_OUTPUT_FULL;
  logic                 MD4_OUTPUT_WRITE;
  logic                 RESULT_VALID;
  logic                 RESULT_MATCH;
  logic                 RESULT_TIMEOUT;
  logic [127:0]         RESULT_HASH;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;

  md4_candidate_driver #(
    .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .CAND_VALID(CAND_VALID), .CAND_READY(CAND_READY), .CAND_DATA(CAND_DATA),
    .CAND_LEN(CAND_LEN), .TARGET_HASH(TARGET_HASH),
    .MD4_START(MD4_START), .MD4_BUSY(MD4_BUSY), .MD4_DONE(MD4_DONE),
    .MD4_INPUT_SIZE(MD4_INPUT_SIZE), .MD4_INPUT_BYTE(MD4_INPUT_BYTE),
    .MD4_INPUT_EMPTY(MD4_INPUT_EMPTY), .MD4_INPUT_READ(MD4_INPUT_READ),
    .MD4_OUTPUT_BYTE(MD4_OUTPUT_BYTE), .MD4_OUTPUT_FULL(MD4_OUTPUT_FULL),
    .MD4_OUTPUT_WRITE(MD4_OUTPUT_WRITE),
    .RESULT_VALID(RESULT_VALID), .RESULT_MATCH(RESULT_MATCH),
    .RESULT_TIMEOUT(RESULT_TIMEOUT), .RESULT_HASH(RESULT_HASH)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  // Count result pulses, sampled away from the rising edge.
  always @(negedge CLK) begin
    if (RESULT_VALID === 1'b1) pulse_cnt++;
  end

  // Hard stop in case something stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Offer one candidate for a single cycle, then scramble the inputs.
  task automatic do_accept(input logic [63:0] data, input logic [3:0] len,
                           input logic [127:0] tgt);
    CAND_DATA   = data;
    CAND_LEN    = len;
    TARGET_HASH = tgt;
    CAND_VALID  = 1'b1;
    tick();
    CAND_VALID  = 1'b0;
    CAND_DATA   = ~data;
    TARGET_HASH = ~tgt;
  endtask

  // Core model: write 16 digest bytes MSB-first, optionally DONE with the last.
  task automatic stream(input logic [127:0] h, input bit done_last,
                        output logic empty_all);
    empty_all = 1'b1;
    for (int k = 0; k < 16; k++) begin
      empty_all        = empty_all & MD4_INPUT_EMPTY;
      MD4_OUTPUT_WRITE = 1'b1;
      MD4_OUTPUT_BYTE  = h[127-8*k -: 8];
      MD4_DONE         = done_last && (k == 15);
      tick();
    end
    MD4_OUTPUT_WRITE = 1'b0;
    MD4_DONE         = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    tick();
    tick();
    checks++;
    if ({CAND_READY, MD4_START, MD4_INPUT_EMPTY, MD4_OUTPUT_FULL, RESULT_VALID,
         RESULT_MATCH, RESULT_TIMEOUT} !== 7'b1011000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 1011000", {CAND_READY, MD4_START,
               MD4_INPUT_EMPTY, MD4_OUTPUT_FULL, RESULT_VALID, RESULT_MATCH, RESULT_TIMEOUT});
    end
    checks++;
    if ({MD4_INPUT_SIZE, MD4_INPUT_BYTE, RESULT_HASH} !== 200'h0) begin
      errors++;
      $display("FAIL reset_data got size=%h byte=%h hash=%h exp all zero",
               MD4_INPUT_SIZE, MD4_INPUT_BYTE, RESULT_HASH);
    end
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_empty();
    int base;
    logic e;
    base = pulse_cnt;
    do_accept(64'h0, 4'd0, H_EMPTY);
    checks++;
    if ({CAND_READY, MD4_START, MD4_INPUT_EMPTY, MD4_OUTPUT_FULL, MD4_INPUT_SIZE} !== {4'b0110, 64'd0}) begin
      errors++;
      $display("FAIL empty_start got rdy=%b st=%b emp=%b full=%b size=%0d exp 0 1 1 0 0",
               CAND_READY, MD4_START, MD4_INPUT_EMPTY, MD4_OUTPUT_FULL, MD4_INPUT_SIZE);
    end
    stream(H_EMPTY, 1'b1, e);
    checks++;
    if (e !== 1'b1) begin
      errors++;
      $display("FAIL empty_throughout got %b exp 1", e);
    end
    checks++;
    if ({RESULT_VALID, RESULT_MATCH, RESULT_TIMEOUT, MD4_START} !== 4'b1100 || RESULT_HASH !== H_EMPTY) begin
      errors++;
      $display("FAIL empty_result got v=%b m=%b t=%b st=%b hash=%h exp 1 1 0 0 %h",
               RESULT_VALID, RESULT_MATCH, RESULT_TIMEOUT, MD4_START, RESULT_HASH, H_EMPTY);
    end
    tick();
    checks++;
    if ({RESULT_VALID, CAND_READY, RESULT_MATCH} !== 3'b011 || pulse_cnt - base !== 1) begin
      errors++;
      $display("FAIL empty_after got v=%b rdy=%b m=%b pulses=%0d exp 0 1 1 1",
               RESULT_VALID, CAND_READY, RESULT_MATCH, pulse_cnt - base);
    end
  endtask

  task automatic test_single_a();
    logic e;
    do_accept(64'h61, 4'd1, H_A);
    checks++;
    if (MD4_INPUT_BYTE !== 8'h61 || MD4_INPUT_EMPTY !== 1'b0 || MD4_INPUT_SIZE !== 64'd1) begin
      errors++;
      $display("FAIL a_start got byte=%h emp=%b size=%0d exp 61 0 1",
               MD4_INPUT_BYTE, MD4_INPUT_EMPTY, MD4_INPUT_SIZE);
    end
    MD4_INPUT_READ = 1'b1;
    tick();
    MD4_INPUT_READ = 1'b0;
    checks++;
    if (MD4_INPUT_EMPTY !== 1'b1 || MD4_INPUT_BYTE !== 8'h00) begin
      errors++;
      $display("FAIL a_after_read got emp=%b byte=%h exp 1 00", MD4_INPUT_EMPTY, MD4_INPUT_BYTE);
    end
    stream(H_A, 1'b1, e);
    checks++;
    if (RESULT_VALID !== 1'b1 || RESULT_MATCH !== 1'b1 || RESULT_HASH !== H_A) begin
      errors++;
      $display("FAIL a_result got v=%b m=%b hash=%h exp 1 1 %h",
               RESULT_VALID, RESULT_MATCH, RESULT_HASH, H_A);
    end
    tick();
  endtask

  task automatic test_mismatch_reads();
    logic [23:0] seen;
    logic e;
    seen = 24'h0;
    do_accept(64'h61, 4'd1, 128'h0);
    for (int i = 0; i < 3; i++) begin
      seen = {seen[15:0], MD4_INPUT_BYTE};
      MD4_INPUT_READ = 1'b1;
      tick();
    end
    MD4_INPUT_READ = 1'b0;
    checks++;
    if (seen !== 24'h610000 || MD4_INPUT_EMPTY !== 1'b1 || MD4_INPUT_BYTE !== 8'h00) begin
      errors++;
      $display("FAIL extra_reads got seen=%h emp=%b byte=%h exp 610000 1 00",
               seen, MD4_INPUT_EMPTY, MD4_INPUT_BYTE);
    end
    stream(H_A, 1'b1, e);
    checks++;
    if ({RESULT_VALID, RESULT_MATCH, RESULT_TIMEOUT} !== 3'b100 || RESULT_HASH !== H_A) begin
      errors++;
      $display("FAIL mismatch_result got v=%b m=%b t=%b hash=%h exp 1 0 0 %h",
               RESULT_VALID, RESULT_MATCH, RESULT_TIMEOUT, RESULT_HASH, H_A);
    end
    tick();
  endtask

  task automatic test_ordering();
    int base;
    logic e;
    // DONE before any digest byte.
    base = pulse_cnt;
    do_accept(64'h0, 4'd0, H_EMPTY);
    MD4_DONE = 1'b1;
    tick();
    MD4_DONE = 1'b0;
    checks++;
    if (RESULT_VALID !== 1'b0 || MD4_START !== 1'b1) begin
      errors++;
      $display("FAIL done_early_wait got v=%b st=%b exp 0 1", RESULT_VALID, MD4_START);
    end
    stream(H_EMPTY, 1'b0, e);
    checks++;
    if (RESULT_VALID !== 1'b1 || RESULT_MATCH !== 1'b1) begin
      errors++;
      $display("FAIL done_early_result got v=%b m=%b exp 1 1", RESULT_VALID, RESULT_MATCH);
    end
    tick();
    tick();
    checks++;
    if (pulse_cnt - base !== 1) begin
      errors++;
      $display("FAIL done_early_pulses got %0d exp 1", pulse_cnt - base);
    end
    // DONE together with the 16th byte.
    base = pulse_cnt;
    do_accept(64'h0, 4'd0, H_EMPTY);
    stream(H_EMPTY, 1'b1, e);
    tick();
    tick();
    checks++;
    if (pulse_cnt - base !== 1 || RESULT_MATCH !== 1'b1) begin
      errors++;
      $display("FAIL done_same_cycle got pulses=%0d m=%b exp 1 1", pulse_cnt - base, RESULT_MATCH);
    end
    // Sixteen bytes, a dropped 17th byte, then DONE.
    base = pulse_cnt;
    do_accept(64'h0, 4'd0, H_EMPTY);
    stream(H_EMPTY, 1'b0, e);
    checks++;
    if (MD4_OUTPUT_FULL !== 1'b1 || RESULT_VALID !== 1'b0 || MD4_START !== 1'b1) begin
      errors++;
      $display("FAIL full_wait got full=%b v=%b st=%b exp 1 0 1",
               MD4_OUTPUT_FULL, RESULT_VALID, MD4_START);
    end
    MD4_OUTPUT_WRITE = 1'b1;
    MD4_OUTPUT_BYTE  = 8'hFF;
    tick();
    MD4_OUTPUT_WRITE = 1'b0;
    MD4_DONE = 1'b1;
    tick();
    MD4_DONE = 1'b0;
    checks++;
    if (RESULT_VALID !== 1'b1 || RESULT_MATCH !== 1'b1 || RESULT_HASH !== H_EMPTY) begin
      errors++;
      $display("FAIL write17_dropped got v=%b m=%b hash=%h exp 1 1 %h",
               RESULT_VALID, RESULT_MATCH, RESULT_HASH, H_EMPTY);
    end
    tick();
    tick();
    checks++;
    if (pulse_cnt - base !== 1) begin
      errors++;
      $display("FAIL write17_pulses got %0d exp 1", pulse_cnt - base);
    end
  endtask

  task automatic test_timeout_clamp();
    int base;
    logic [63:0] seen;
    base = pulse_cnt;
    seen = 64'h0;
    do_accept(64'h0807060504030201, 4'd12, 128'h0);
    checks++;
    if (MD4_INPUT_SIZE !== 64'd8 || MD4_INPUT_BYTE !== 8'h01 || MD4_INPUT_EMPTY !== 1'b0) begin
      errors++;
      $display("FAIL clamp_start got size=%0d byte=%h emp=%b exp 8 01 0",
               MD4_INPUT_SIZE, MD4_INPUT_BYTE, MD4_INPUT_EMPTY);
    end
    for (int i = 0; i < 8; i++) begin
      seen = {seen[55:0], MD4_INPUT_BYTE};
      MD4_INPUT_READ = 1'b1;
      tick();
    end
    MD4_INPUT_READ = 1'b0;
    checks++;
    if (seen !== 64'h0102030405060708 || MD4_INPUT_EMPTY !== 1'b1) begin
      errors++;
      $display("FAIL clamp_bytes got seen=%h emp=%b exp 0102030405060708 1", seen, MD4_INPUT_EMPTY);
    end
    for (int i = 8; i < TMO - 1; i++) tick();
    checks++;
    if (RESULT_VALID !== 1'b0 || MD4_START !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early got v=%b st=%b exp 0 1 at run cycle %0d",
               RESULT_VALID, MD4_START, TMO - 1);
    end
    tick();
    checks++;
    if ({RESULT_VALID, RESULT_TIMEOUT, RESULT_MATCH, MD4_START, MD4_OUTPUT_FULL,
         MD4_INPUT_EMPTY} !== 6'b110011) begin
      errors++;
      $display("FAIL timeout_result got v=%b t=%b m=%b st=%b full=%b emp=%b exp 1 1 0 0 1 1",
               RESULT_VALID, RESULT_TIMEOUT, RESULT_MATCH, MD4_START, MD4_OUTPUT_FULL, MD4_INPUT_EMPTY);
    end
    tick();
    checks++;
    if ({CAND_READY, RESULT_VALID, RESULT_TIMEOUT} !== 3'b101 || pulse_cnt - base !== 1) begin
      errors++;
      $display("FAIL timeout_after got rdy=%b v=%b t=%b pulses=%0d exp 1 0 1 1",
               CAND_READY, RESULT_VALID, RESULT_TIMEOUT, pulse_cnt - base);
    end
  endtask

  task automatic test_reset_mid_run();
    int base;
    logic e;
    base = pulse_cnt;
    do_accept(64'h61, 4'd1, H_A);
    for (int k = 0; k < 5; k++) begin
      MD4_OUTPUT_WRITE = 1'b1;
      MD4_OUTPUT_BYTE  = H_A[127-8*k -: 8];
      tick();
    end
    MD4_OUTPUT_WRITE = 1'b0;
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    checks++;
    if ({MD4_START, MD4_OUTPUT_FULL, MD4_INPUT_EMPTY, CAND_READY, RESULT_VALID} !== 5'b01110 ||
        RESULT_HASH !== 128'h0) begin
      errors++;
      $display("FAIL midrun_reset got st=%b full=%b emp=%b rdy=%b v=%b hash=%h exp 0 1 1 1 0 0",
               MD4_START, MD4_OUTPUT_FULL, MD4_INPUT_EMPTY, CAND_READY, RESULT_VALID, RESULT_HASH);
    end
    tick();
    checks++;
    if (pulse_cnt - base !== 0) begin
      errors++;
      $display("FAIL midrun_pulses got %0d exp 0", pulse_cnt - base);
    end
    do_accept(64'h61, 4'd1, H_A);
    stream(H_A, 1'b1, e);
    checks++;
    if (RESULT_VALID !== 1'b1 || RESULT_MATCH !== 1'b1 || RESULT_HASH !== H_A) begin
      errors++;
      $display("FAIL post_reset_job got v=%b m=%b hash=%h exp 1 1 %h",
               RESULT_VALID, RESULT_MATCH, RESULT_HASH, H_A);
    end
    tick();
  endtask

  // Test sequence.
  initial begin
    RESET_N          = 1'b0;
    CAND_VALID       = 1'b0;
    CAND_DATA        = 64'h0;
    CAND_LEN         = 4'd0;
    TARGET_HASH      = 128'h0;
    MD4_BUSY         = 1'b0;
    MD4_DONE         = 1'b0;
    MD4_INPUT_READ   = 1'b0;
    MD4_OUTPUT_BYTE  = 8'h00;
    MD4_OUTPUT_WRITE = 1'b0;
    test_reset();
    test_empty();
    test_single_a();
    test_mismatch_reads();
    test_ordering();
    test_timeout_clamp();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
